// File: rtl/stream_slave_capture.sv
// AXI-Stream frame sink: FWFT FIFO for a local reader, frame length/count and overrun discard.
// Define STREAM_SUM_EN to add per-frame signed R/I sums (frame_sum_r, frame_sum_i).
module stream_slave_capture #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int MAX_FRAME_LEN        = 2048,
  parameter int LEN_W                = 12
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              rd_en,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic                              rd_last,
  output logic                              rd_empty,
  output logic                              frame_done,
  output logic [LEN_W-1:0]                  frame_len,
  output logic [LEN_W-1:0]                  frame_cnt,
  output logic                              frame_err,
  output logic [1:0]                        err_sticky,
  input  logic                              err_clear
`ifdef STREAM_SUM_EN
  ,
  output logic signed [C_S_AXIS_TDATA_WIDTH/2+LEN_W-1:0] frame_sum_r,
  output logic signed [C_S_AXIS_TDATA_WIDTH/2+LEN_W-1:0] frame_sum_i
`endif
);

  localparam int W     = C_S_AXIS_TDATA_WIDTH;
  localparam int HW    = W / 2;
  localparam int SW    = HW + LEN_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FRAME   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W:0]   cnt_inc;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             tready_q, tready_d;
  logic             done_q, err_q;
  logic [LEN_W-1:0] len_q, fcnt_q;
  logic [1:0]       sticky_q, sticky_d;
  logic [W:0]       mem [FIFO_DEPTH];
  logic [W:0]       head;
  logic             accept, wr_en, rd_fire, empty, good_end, overrun, strb_bad;

  assign accept   = S_AXIS_TVALID & tready_q;
  assign wr_en    = accept & (state_q != ST_DISCARD);
  assign empty    = (count_q == '0);
  assign rd_fire  = rd_en & ~empty;
  assign strb_bad = (S_AXIS_TSTRB != '1);
  // cnt_q is 0 whenever the FSM is in IDLE, so cnt_inc is also the single-beat length.
  assign cnt_inc  = {1'b0, cnt_q} + (LEN_W+1)'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_end = 1'b0;
    overrun  = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (S_AXIS_TLAST) begin
            good_end = 1'b1;
          end else begin
            state_d = ST_FRAME;
            cnt_d   = LEN_W'(1);
          end
        end
        ST_FRAME: begin
          if (S_AXIS_TLAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            good_end = 1'b1;
          end else if (cnt_inc == (LEN_W+1)'(MAX_FRAME_LEN)) begin
            state_d = ST_DISCARD;
            cnt_d   = '0;
            overrun = 1'b1;
          end else begin
            cnt_d = cnt_inc[LEN_W-1:0];
          end
        end
        ST_DISCARD: begin
          if (S_AXIS_TLAST) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    count_d  = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_fire);
    // Ready is registered from next state so TVALID never reaches TREADY combinationally.
    tready_d = (state_d == ST_DISCARD) | (count_d != (PTR_W+1)'(FIFO_DEPTH));
    sticky_d[0] = (sticky_q[0] & ~err_clear) | overrun;
    sticky_d[1] = (sticky_q[1] & ~err_clear) | (accept & strb_bad);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
      fcnt_q   <= '0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      tready_q <= tready_d;
      done_q   <= good_end;
      err_q    <= overrun;
      sticky_q <= sticky_d;
      if (wr_en)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (good_end) begin
        len_q  <= cnt_inc[LEN_W-1:0];
        fcnt_q <= fcnt_q + LEN_W'(1);
      end
    end
  end

  // NOTE: storage is not reset; rd_data/rd_last are masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TDATA};
  end

  assign head          = mem[rd_ptr_q];
  assign rd_data       = empty ? '0 : head[W-1:0];
  assign rd_last       = ~empty & head[W];
  assign rd_empty      = empty;
  assign S_AXIS_TREADY = tready_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;
  assign frame_len     = len_q;
  assign frame_cnt     = fcnt_q;
  assign err_sticky    = sticky_q;

`ifdef STREAM_SUM_EN
  logic signed [SW-1:0] beat_r, beat_i, acc_r_q, acc_i_q, acc_r_nxt, acc_i_nxt;
  logic signed [SW-1:0] sum_r_q, sum_i_q;

  assign beat_r    = {{LEN_W{S_AXIS_TDATA[W-1]}}, S_AXIS_TDATA[W-1:HW]};
  assign beat_i    = {{LEN_W{S_AXIS_TDATA[HW-1]}}, S_AXIS_TDATA[HW-1:0]};
  // The first beat of a frame restarts the accumulators rather than adding to them.
  assign acc_r_nxt = (state_q == ST_IDLE) ? beat_r : acc_r_q + beat_r;
  assign acc_i_nxt = (state_q == ST_IDLE) ? beat_i : acc_i_q + beat_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r_q <= '0;
      acc_i_q <= '0;
      sum_r_q <= '0;
      sum_i_q <= '0;
    end else begin
      if (wr_en) begin
        acc_r_q <= acc_r_nxt;
        acc_i_q <= acc_i_nxt;
      end
      if (good_end) begin
        sum_r_q <= acc_r_nxt;
        sum_i_q <= acc_i_nxt;
      end
    end
  end

  assign frame_sum_r = sum_r_q;
  assign frame_sum_i = sum_i_q;
`endif

endmodule

// File: tb/tb_stream_slave_capture.sv
// Directed self-checking bench for stream_slave_capture; sum checks run only with STREAM_SUM_EN.
module tb_stream_slave_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast, tvalid, tready;
  logic        rd_en, rd_last, rd_empty;
  logic [31:0] rd_data;
  logic        frame_done, frame_err, err_clear;
  logic [11:0] frame_len, frame_cnt;
  logic [1:0]  err_sticky;
`ifdef STREAM_SUM_EN
  logic [27:0] frame_sum_r, frame_sum_i;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt, err_cnt, pop_k, last_idx;
  logic pop_en;

  always #5 clk = ~clk;

  stream_slave_capture dut (
    .clk          (clk),
    .resetn       (resetn),
    .S_AXIS_TDATA (tdata),
    .S_AXIS_TSTRB (tstrb),
    .S_AXIS_TLAST (tlast),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .rd_empty     (rd_empty),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .frame_cnt    (frame_cnt),
    .frame_err    (frame_err),
    .err_sticky   (err_sticky),
    .err_clear    (err_clear)
`ifdef STREAM_SUM_EN
    ,
    .frame_sum_r  (frame_sum_r),
    .frame_sum_i  (frame_sum_i)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Beat i of a frame carries R = i, I = -i.
  function automatic logic [31:0] mk(input int i);
    logic [15:0] r, im;
    r  = 16'(i);
    im = 16'(-i);
    return {r, im};
  endfunction

  // One clock cycle: observe pulses and FIFO pops mid-cycle, then land 1ns after the edge.
  task automatic tick();
    @(negedge clk);
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
    if (pop_en && rd_en && !rd_empty) begin
      pop_k++;
      check("pop_data", {32'd0, rd_data}, {32'd0, mk(pop_k)});
      check("pop_last", rd_last, (pop_k == last_idx));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] d, input logic l);
    logic rdy;
    int   guard;
    guard  = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    do begin
      rdy = tready;
      tick();
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) check("accept_timeout", rdy, 1'b1);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last_b, input int tlast_at);
    for (int b = first; b <= last_b; b++) send_one(mk(b), (b == tlast_at));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && !rd_empty; i++) tick();
    check("drain_empty", rd_empty, 1'b1);
    tick();
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    tvalid    = 1'b0;
    tlast     = 1'b0;
    tstrb     = 4'hF;
    rd_en     = 1'b0;
    err_clear = 1'b0;
    pop_en    = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    done_cnt = 0;
    err_cnt  = 0;
    pop_k    = 0;
  endtask

  initial begin
    int   b;
    logic rdy;
    resetn = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = 4'hF; tlast = 1'b0;
    rd_en = 1'b0; err_clear = 1'b0; pop_en = 1'b0;
    done_cnt = 0; err_cnt = 0; pop_k = 0; last_idx = 0;

    // Reset state
    tick(); tick();
    check("rst_tready", tready, 1'b0);
    check("rst_empty", rd_empty, 1'b1);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_len", frame_len, 12'd0);
    check("rst_cnt", frame_cnt, 12'd0);
    check("rst_sticky", err_sticky, 2'b00);
    resetn = 1'b1;
    tick();
    check("tready_after_rst", tready, 1'b1);

    // 1) 1613-beat frame with concurrent reader
    rd_en = 1'b1; pop_en = 1'b1; pop_k = 0; last_idx = 1613;
    send_beats(1, 1613, 1613);
    check("t1_done_pulse", frame_done, 1'b1);
    check("t1_len", frame_len, 12'd1613);
    check("t1_cnt", frame_cnt, 12'd1);
    tick();
    check("t1_done_low", frame_done, 1'b0);
    wait_drain();
    check("t1_done_once", done_cnt, 1);
    check("t1_pops", pop_k, 1613);
    check("t1_no_err", err_cnt, 0);

    // 2) Backpressure: FIFO fills to 16, one pop admits exactly one more beat
    do_reset();
    send_one(mk(1), 1'b0);
    check("t2_fwft_empty", rd_empty, 1'b0);
    check("t2_fwft_data", rd_data, mk(1));
    check("t2_fwft_last", rd_last, 1'b0);
    b = 2;
    tvalid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tdata = mk(b);
      rdy = tready;
      tick();
      if (rdy) b++;
    end
    check("t2_accepted_full", b - 1, 16);
    check("t2_tready_full", tready, 1'b0);
    pop_en = 1'b1; pop_k = 0; last_idx = 0;
    rd_en = 1'b1;
    tdata = mk(b);
    rdy = tready;
    tick();
    if (rdy) b++;
    rd_en = 1'b0;
    check("t2_tready_after_pop", tready, 1'b1);
    check("t2_one_pop", pop_k, 1);
    rdy = tready;
    tick();
    if (rdy) b++;
    check("t2_accepted_after_pop", b - 1, 17);
    check("t2_tready_refull", tready, 1'b0);
    tvalid = 1'b0;
    rd_en = 1'b1;
    wait_drain();
    check("t2_pops", pop_k, 17);

    // 3) Overrun: beat 2048 without TLAST, then discard through beat 2100
    do_reset();
    rd_en = 1'b1; pop_en = 1'b1; pop_k = 0; last_idx = 0;
    send_beats(1, 2048, 0);
    check("t3_err_pulse", frame_err, 1'b1);
    check("t3_sticky", err_sticky, 2'b01);
    send_beats(2049, 2100, 2100);
    check("t3_tready_discard", tready, 1'b1);
    wait_drain();
    check("t3_err_once", err_cnt, 1);
    check("t3_no_done", done_cnt, 0);
    check("t3_pops", pop_k, 2048);
    check("t3_cnt", frame_cnt, 12'd0);
    pop_k = 0; last_idx = 5;
    send_beats(1, 5, 5);
    wait_drain();
    check("t3_next_len", frame_len, 12'd5);
    check("t3_next_cnt", frame_cnt, 12'd1);
    check("t3_next_pops", pop_k, 5);
    check("t3_next_done", done_cnt, 1);

    // 4) Single-beat frame from IDLE, then back-to-back frames
    do_reset();
    rd_en = 1'b1;
    send_beats(1, 1, 1);
    check("t4_done_pulse", frame_done, 1'b1);
    check("t4_len1", frame_len, 12'd1);
    send_beats(1, 3, 3);
    send_beats(1, 2, 2);
    tick(); tick();
    check("t4_cnt", frame_cnt, 12'd3);
    check("t4_len_last", frame_len, 12'd2);
    check("t4_dones", done_cnt, 3);

    // 5) Asynchronous reset mid-frame
    do_reset();
    rd_en = 1'b1;
    send_beats(1, 3, 3);
    send_beats(1, 700, 0);
    rd_en = 1'b0;
    check("t5_pre_cnt", frame_cnt, 12'd1);
    check("t5_pre_empty", rd_empty, 1'b0);
    resetn = 1'b0;
    #1;
    check("t5_rst_tready", tready, 1'b0);
    check("t5_rst_empty", rd_empty, 1'b1);
    check("t5_rst_data", rd_data, 32'd0);
    check("t5_rst_len", frame_len, 12'd0);
    check("t5_rst_cnt", frame_cnt, 12'd0);
    tick();
    resetn = 1'b1;
    tick();
    rd_en = 1'b1; pop_en = 1'b1; pop_k = 0; last_idx = 10;
    send_beats(1, 10, 10);
    check("t5_len", frame_len, 12'd10);
    check("t5_cnt", frame_cnt, 12'd1);
    wait_drain();
    check("t5_pops", pop_k, 10);

    // 6) Bad TSTRB beat, frame sums, sticky clear and set-over-clear priority
    do_reset();
    send_one({16'd1, 16'hFFFF}, 1'b0);
    tstrb = 4'b0111;
    send_one({16'd2, 16'hFFFF}, 1'b0);
    tstrb = 4'hF;
    send_one({16'd3, 16'hFFFF}, 1'b1);
    check("t6_done", frame_done, 1'b1);
    check("t6_len", frame_len, 12'd3);
    check("t6_sticky_strb", err_sticky, 2'b10);
    check("t6_head", rd_data, {16'd1, 16'hFFFF});
`ifdef STREAM_SUM_EN
    check("t6_sum_r", frame_sum_r, 28'd6);
    check("t6_sum_i", frame_sum_i, 28'hFFFFFFD);
`endif
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t6_sticky_cleared", err_sticky, 2'b00);
    rd_en = 1'b1;
    wait_drain();
    rd_en = 1'b0;
    err_clear = 1'b1;
    tstrb = 4'b0111;
    send_one(mk(1), 1'b1);
    err_clear = 1'b0;
    tstrb = 4'hF;
    check("t6_set_wins", err_sticky, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, want completion", n_checks);
    $fatal(1);
  end

endmodule
